r_ptr_flags_ctrl: RTL and testbench

// - Read-domain controller of the async FIFO, next generation: read pointer, RAM address, empty flag,

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/d_ff_async.sv | 28 ++
 rtl/gray_ptr_sync.sv | 43 ++++
 rtl/r_ptr_flags_ctrl.sv | 126 ++++++++++++
 tb/tb_r_ptr_flags_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO pointer/flag controllers (read and
// write side).
//   - SYNC_STAGES_MIN/MAX : legal range of the gray-pointer synchroniser depth
//   - bin2gray / gray2bin : pointer code conversions. They work on a wide word;
//                           callers zero-extend narrower pointers and truncate
//                           the result. Leading zeros do not change either
//                           code, so the narrow result is exact.
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, built with doubling shifts:
  // after the loop, bit i holds the XOR of gray bits i..MSB.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/d_ff_async.sv
// ----------------------------------------------------------------------------
// d_ff_async
// Generic register with asynchronous active-low reset to a parameterised
// value.
//   clk    in   1      clock
//   rst_n  in   1      asynchronous active-low reset
//   i_d    in   WIDTH  next value
//   o_q    out  WIDTH  registered value (RST_VAL while in reset)
// ----------------------------------------------------------------------------
module d_ff_async #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= RST_VAL;
    end else begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/gray_ptr_sync.sv
// ----------------------------------------------------------------------------
// gray_ptr_sync
// Multi-flop synchroniser for a gray-coded FIFO pointer crossing into this
// clock domain. Used by both the read and the write side of the FIFO.
//   clk    in   1      destination clock
//   rst_n  in   1      asynchronous active-low reset (chain clears to 0)
//   i_d    in   WIDTH  gray pointer from the other clock domain
//   o_q    out  WIDTH  pointer after STAGES flops
// ----------------------------------------------------------------------------
module gray_ptr_sync
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES out of legal range");
  end

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/r_ptr_flags_ctrl.sv
// ----------------------------------------------------------------------------
// r_ptr_flags_ctrl
// Read-domain controller of the async FIFO: read pointer, RAM read address,
// empty / almost-empty flags, read-side fill level and (optionally) a sticky
// underflow flag.
//
// Parameters
//   ADDRESS_SIZE   RAM address width; depth = 2**ADDRESS_SIZE
//   SYNC_STAGES    flops in the w_ptr synchroniser (2..4)
//   AEMPTY_THRESH  r_aempty asserted when level <= AEMPTY_THRESH
//
// Ports
//   r_clk        in   1               read clock
//   rrst_n       in   1               asynchronous active-low reset
//   r_en         in   1               read request (ignored while empty)
//   r_uf_clr     in   1               clear underflow flag   (optional)
//   r_underflow  out  1               sticky underflow flag  (optional)
//   w_ptr        in   ADDRESS_SIZE+1  gray write pointer, write-clock domain
//   r_ptr        out  ADDRESS_SIZE+1  gray read pointer, registered
//   r_addr       out  ADDRESS_SIZE    binary RAM read address
//   r_empty      out  1               FIFO empty, registered
//   r_aempty     out  1               almost empty, registered
//   r_level      out  ADDRESS_SIZE+1  words available to read, registered
//
// Configuration macro
//   R_UNDERFLOW_FLAG_EN  defined: r_uf_clr / r_underflow ports and the
//                        underflow logic exist; undefined: both are absent.
// ----------------------------------------------------------------------------
module r_ptr_flags_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE  = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  r_en,
`ifdef R_UNDERFLOW_FLAG_EN
  input  logic                  r_uf_clr,
  output logic                  r_underflow,
`endif
  input  logic [ADDRESS_SIZE:0] w_ptr,
  output logic [ADDRESS_SIZE:0] r_ptr,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                  r_empty,
  output logic                  r_aempty,
  output logic [ADDRESS_SIZE:0] r_level
);

  localparam int unsigned PTR_W = ADDRESS_SIZE + 1;

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] w_rq_wptr;
  logic [PTR_W-1:0] w_wbin_s;
  logic             w_rd_fire;
  logic [PTR_W-1:0] w_bnext;
  logic [PTR_W-1:0] w_gnext;
  logic             w_empty_next;
  logic             w_aempty_next;
  logic [PTR_W-1:0] w_level_next;

  // Write pointer into the read domain
  gray_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (rrst_n),
    .i_d   (w_ptr),
    .o_q   (w_rq_wptr)
  );

  always_comb begin
    w_wbin_s      = PTR_W'(gray2bin(PTR_MAX_W'(w_rq_wptr)));
    w_rd_fire     = r_en & ~r_empty;
    w_bnext       = r_bin + PTR_W'(w_rd_fire);
    w_gnext       = PTR_W'(bin2gray(PTR_MAX_W'(w_bnext)));
    // Flags are computed from the post-read pointer so that a final read
    // coinciding with a newly synchronised write never flashes empty.
    w_empty_next  = (w_gnext == w_rq_wptr);
    w_level_next  = w_wbin_s - w_bnext;
    w_aempty_next = (w_level_next <= PTR_W'(AEMPTY_THRESH));
  end

  d_ff_async #(.WIDTH(PTR_W), .RST_VAL('0)) u_bin_ff (
    .clk (r_clk), .rst_n (rrst_n), .i_d (w_bnext), .o_q (r_bin)
  );

  d_ff_async #(.WIDTH(PTR_W), .RST_VAL('0)) u_ptr_ff (
    .clk (r_clk), .rst_n (rrst_n), .i_d (w_gnext), .o_q (r_ptr)
  );

  d_ff_async #(.WIDTH(1), .RST_VAL(1'b1)) u_empty_ff (
    .clk (r_clk), .rst_n (rrst_n), .i_d (w_empty_next), .o_q (r_empty)
  );

  d_ff_async #(.WIDTH(1), .RST_VAL(1'b1)) u_aempty_ff (
    .clk (r_clk), .rst_n (rrst_n), .i_d (w_aempty_next), .o_q (r_aempty)
  );

  d_ff_async #(.WIDTH(PTR_W), .RST_VAL('0)) u_level_ff (
    .clk (r_clk), .rst_n (rrst_n), .i_d (w_level_next), .o_q (r_level)
  );

  assign r_addr = r_bin[ADDRESS_SIZE-1:0];

`ifdef R_UNDERFLOW_FLAG_EN
  logic w_uf_next;

  // Set has priority over a simultaneous clear.
  always_comb begin
    w_uf_next = r_underflow;
    if (r_en && r_empty) begin
      w_uf_next = 1'b1;
    end else if (r_uf_clr) begin
      w_uf_next = 1'b0;
    end
  end

  d_ff_async #(.WIDTH(1), .RST_VAL(1'b0)) u_uf_ff (
    .clk (r_clk), .rst_n (rrst_n), .i_d (w_uf_next), .o_q (r_underflow)
  );
`endif

endmodule

// File: tb/tb_r_ptr_flags_ctrl.sv
module tb_r_ptr_flags_ctrl;

  localparam int unsigned AS     = 4;
  localparam int unsigned SS     = 2;
  localparam int unsigned THRESH = 2;
  localparam int          DEPTH  = 1 << AS;
  localparam int          PMOD   = 2 * DEPTH;

  logic          r_clk = 1'b0;
  logic          rrst_n = 1'b1;
  logic          r_en = 1'b0;
  logic          r_uf_clr = 1'b0;
  logic [AS:0]   w_ptr = '0;
  logic [AS:0]   r_ptr;
  logic [AS-1:0] r_addr;
  logic          r_empty;
  logic          r_aempty;
  logic [AS:0]   r_level;
`ifdef R_UNDERFLOW_FLAG_EN
  logic          r_underflow;
`endif

  r_ptr_flags_ctrl #(
    .ADDRESS_SIZE  (AS),
    .SYNC_STAGES   (SS),
    .AEMPTY_THRESH (THRESH)
  ) dut (
    .r_clk       (r_clk),
    .rrst_n      (rrst_n),
    .r_en        (r_en),
`ifdef R_UNDERFLOW_FLAG_EN
    .r_uf_clr    (r_uf_clr),
    .r_underflow (r_underflow),
`endif
    .w_ptr       (w_ptr),
    .r_ptr       (r_ptr),
    .r_addr      (r_addr),
    .r_empty     (r_empty),
    .r_aempty    (r_aempty),
    .r_level     (r_level)
  );

  always #5 r_clk = ~r_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: total words written / read, and the write totals as
  // the read domain will see them after the synchroniser delay.
  int wr_total;
  int rd_total;
  int hist[$];
  int m_level;
  bit m_empty;
  bit m_aempty;
  bit m_uf;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_total = 0;
    rd_total = 0;
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(0);
    m_level  = 0;
    m_empty  = 1'b1;
    m_aempty = 1'b1;
    m_uf     = 1'b0;
    w_ptr    = '0;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".empty"},  r_empty,  m_empty);
    check_eq({where, ".aempty"}, r_aempty, m_aempty);
    check_eq({where, ".level"},  r_level,  m_level);
    check_eq({where, ".ptr"},    r_ptr,    gray_of(rd_total % PMOD));
    check_eq({where, ".addr"},   r_addr,   rd_total % DEPTH);
`ifdef R_UNDERFLOW_FLAG_EN
    check_eq({where, ".uf"},     r_underflow, m_uf);
`endif
  endtask

  // One read-clock edge: drive w_ptr from the write total, advance the
  // model with the inputs as they stand, then compare after the edge.
  task automatic tick(input string where);
    int vis;
    w_ptr = (AS+1)'(gray_of(wr_total % PMOD));
    if (r_en && m_empty) m_uf = 1'b1;
    else if (r_uf_clr)   m_uf = 1'b0;
    if (r_en && !m_empty) rd_total++;
    vis = hist.pop_front();
    hist.push_back(wr_total);
    m_level  = vis - rd_total;
    m_empty  = (m_level == 0);
    m_aempty = (m_level <= THRESH);
    @(posedge r_clk);
    #1;
    check_outputs(where);
  endtask

  task automatic random_phase(input int cycles, input string where);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 2) != 0 && (wr_total - rd_total) < DEPTH) wr_total++;
      r_en     = ($urandom_range(0, 3) != 0);
      r_uf_clr = ($urandom_range(0, 7) == 0);
      tick(where);
    end
    r_en     = 1'b0;
    r_uf_clr = 1'b0;
  endtask

  initial begin
    model_reset();

    // Async reset with no clock edge
    #3 rrst_n = 1'b0;
    #1;
    check_outputs("reset");
    @(posedge r_clk);
    @(posedge r_clk);
    #2 rrst_n = 1'b1;

    // Fill to 5, then read all of them
    wr_total = 5;
    for (int i = 0; i < 3; i++) tick("fill");
    check_eq("fill.level5", r_level, 5);
    check_eq("fill.aempty0", r_aempty, 0);
    r_en = 1'b1;
    for (int i = 0; i < 5; i++) tick("drain5");
    check_eq("drain5.empty", r_empty, 1);
    check_eq("drain5.addr", r_addr, 5);
    r_en = 1'b0;
    tick("idle");

    // Streaming with the write pointer leading, through the wrap
    for (int c = 0; c < 600 && rd_total < 40; c++) begin
      if ($urandom_range(0, 3) != 0 && (wr_total - rd_total) < DEPTH) wr_total++;
      r_en = ($urandom_range(0, 3) != 0);
      tick("stream");
    end
    r_en = 1'b0;
    check_eq("stream.reads_reached_40", rd_total, 40);
    check_eq("stream.ptr_gray8", r_ptr, 12);

    // Drain to empty
    r_en = 1'b1;
    for (int c = 0; c < 200 && !m_empty; c++) tick("drain");
    check_eq("drain.empty", r_empty, 1);

    // Reads while empty are ignored
    for (int i = 0; i < 3; i++) tick("empty_rd");
`ifdef R_UNDERFLOW_FLAG_EN
    check_eq("uf.set", r_underflow, 1);
    r_uf_clr = 1'b1;
    tick("uf.set_wins");
    check_eq("uf.set_wins_hold", r_underflow, 1);
    r_en = 1'b0;
    tick("uf.clear");
    check_eq("uf.cleared", r_underflow, 0);
    r_uf_clr = 1'b0;
`endif
    r_en = 1'b0;

    // Coincident: last word read on the edge a new write becomes visible
    wr_total++;
    for (int i = 0; i < 3; i++) tick("coinc.pre");
    check_eq("coinc.level1", r_level, 1);
    wr_total++;
    tick("coinc.a");
    tick("coinc.b");
    r_en = 1'b1;
    tick("coinc.c");
    check_eq("coinc.empty0", r_empty, 0);
    check_eq("coinc.level1b", r_level, 1);
    r_en = 1'b0;

    // Mid-operation reset with level 7
    wr_total += 6;
    for (int i = 0; i < 3; i++) tick("mid.pre");
    check_eq("mid.level7", r_level, 7);
    #2 rrst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mid.reset");
    #2 rrst_n = 1'b1;

    // Resume with random traffic including reads while empty
    random_phase(400, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit %0d", 200000);
    $fatal(1, "timeout");
  end

endmodule
